// File: rtl/matrix_scan_controller.sv
// Row-scan refresh for an 8x8 LED matrix with double-buffered frame and frame-aligned swap.
// Latency: 1 cycle from enable to row drive; all outputs registered.
// Backpressure: wr_ready drops while a swap is pending, freezing the back buffer until the next frame boundary.
module matrix_scan_controller #(
    parameter int ROW_CYCLES   = 4,
    parameter int BLANK_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [2:0] wr_row,
    input  logic [7:0] wr_data,
    input  logic       swap_req,
    output logic       swap_pending,
    output logic [7:0] row_sel,
    output logic [7:0] col_data,
    output logic       frame_start
);

    typedef enum logic [1:0] {IDLE, DWELL, BLANK} state_t;

    localparam logic [8:0] ROW_LOAD   = 9'(ROW_CYCLES - 1);
    localparam logic [8:0] BLANK_LOAD = 9'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);

    state_t     state_q, state_n;
    logic [2:0] row_q, row_n;
    logic [8:0] cnt_q, cnt_n;
    logic       front_q, front_n;
    logic       swap_pending_n;
    logic       boundary;
    logic [7:0] row_sel_n, col_data_n;
    logic [7:0] fb [2][8];

    assign wr_ready = !swap_pending;

    always_comb begin
        state_n  = state_q;
        row_n    = row_q;
        cnt_n    = cnt_q;
        boundary = 1'b0;
        if (!enable) begin
            state_n = IDLE;
            row_n   = 3'd0;
            cnt_n   = 9'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_n  = DWELL;
                    row_n    = 3'd0;
                    cnt_n    = ROW_LOAD;
                    boundary = 1'b1;
                end
                DWELL: begin
                    if (cnt_q == 9'd0) begin
                        if (BLANK_CYCLES == 0) begin
                            state_n  = DWELL;
                            row_n    = row_q + 3'd1;
                            cnt_n    = ROW_LOAD;
                            boundary = (row_q == 3'd7);
                        end else begin
                            state_n = BLANK;
                            cnt_n   = BLANK_LOAD;
                        end
                    end else begin
                        cnt_n = cnt_q - 9'd1;
                    end
                end
                BLANK: begin
                    if (cnt_q == 9'd0) begin
                        state_n  = DWELL;
                        row_n    = row_q + 3'd1;
                        cnt_n    = ROW_LOAD;
                        boundary = (row_q == 3'd7);
                    end else begin
                        cnt_n = cnt_q - 9'd1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end

        // The swap lands in the same cycle row 0 is first driven, so row 0 already shows the new front.
        front_n        = front_q ^ (boundary & swap_pending);
        swap_pending_n = (boundary && swap_pending) ? 1'b0 : (swap_pending | swap_req);

        row_sel_n  = 8'h00;
        col_data_n = 8'h00;
        if (state_n == DWELL) begin
            row_sel_n  = 8'h01 << row_n;
            col_data_n = fb[front_n][row_n];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            row_q        <= 3'd0;
            cnt_q        <= 9'd0;
            front_q      <= 1'b0;
            swap_pending <= 1'b0;
            row_sel      <= 8'h00;
            col_data     <= 8'h00;
            frame_start  <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < 8; r++) begin
                    fb[b][r] <= 8'h00;
                end
            end
        end else begin
            state_q      <= state_n;
            row_q        <= row_n;
            cnt_q        <= cnt_n;
            front_q      <= front_n;
            swap_pending <= swap_pending_n;
            row_sel      <= row_sel_n;
            col_data     <= col_data_n;
            frame_start  <= boundary;
            if (wr_valid && wr_ready) begin
                fb[!front_q][wr_row] <= wr_data;
            end
        end
    end

endmodule

// File: tb/tb_matrix_scan_controller.sv
// Directed bench: default instance (4 dwell + 1 blank) and a 1-cycle/no-blank instance.
module tb_matrix_scan_controller;

    logic       clk = 1'b0;
    logic       rst, enable, wr_valid, swap_req;
    logic [2:0] wr_row;
    logic [7:0] wr_data;
    logic       wr_ready, swap_pending, frame_start;
    logic [7:0] row_sel, col_data;

    logic       enable2, wr_valid2, swap_req2;
    logic [2:0] wr_row2;
    logic [7:0] wr_data2;
    logic       wr_ready2, swap_pending2, frame_start2;
    logic [7:0] row_sel2, col_data2;

    always #5 clk = ~clk;

    matrix_scan_controller #(.ROW_CYCLES(4), .BLANK_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .enable(enable), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_row(wr_row), .wr_data(wr_data), .swap_req(swap_req), .swap_pending(swap_pending),
        .row_sel(row_sel), .col_data(col_data), .frame_start(frame_start)
    );

    matrix_scan_controller #(.ROW_CYCLES(1), .BLANK_CYCLES(0)) dut_fast (
        .clk(clk), .rst(rst), .enable(enable2), .wr_valid(wr_valid2), .wr_ready(wr_ready2),
        .wr_row(wr_row2), .wr_data(wr_data2), .swap_req(swap_req2), .swap_pending(swap_pending2),
        .row_sel(row_sel2), .col_data(col_data2), .frame_start(frame_start2)
    );

    typedef struct {
        logic       en;
        logic       wv;
        logic [2:0] wrow;
        logic [7:0] wdat;
        logic       sreq;
        logic [7:0] exp_row;
        logic [7:0] exp_col;
        logic       exp_fs;
        logic       exp_sp;
    } vec_t;

    vec_t       vecs [11];
    int         nvec  = 0;
    int         nfail = 0;
    int         t     = 0;
    logic [7:0] shown [8];
    logic       exp_sp = 1'b0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s t=%0d: got %h, expected %h", nm, t, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string nm);
        chk({nm, "_row"}, row_sel, 8'h00);
        chk({nm, "_col"}, col_data, 8'h00);
        chk({nm, "_fs"}, {7'd0, frame_start}, 8'h00);
    endtask

    // Default geometry: 5-cycle row slot (4 dwell, 1 blank), 40-cycle frame; t counts from first row-0 cycle.
    task automatic scan(input int n);
        for (int k = 0; k < n; k++) begin
            int         pos;
            int         row;
            logic [7:0] er, ec;
            tick();
            pos = t % 5;
            row = (t / 5) % 8;
            er  = (pos < 4) ? (8'h01 << row) : 8'h00;
            ec  = (pos < 4) ? shown[row] : 8'h00;
            chk("scan_row", row_sel, er);
            chk("scan_col", col_data, ec);
            chk("scan_fs", {7'd0, frame_start}, {7'd0, (t % 40) == 0});
            chk("scan_sp", {7'd0, swap_pending}, {7'd0, exp_sp});
            t++;
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            vecs[i] = '{en: 1'b0, wv: 1'b1, wrow: 3'(i), wdat: 8'h01 << i, sreq: 1'b0,
                        exp_row: 8'h00, exp_col: 8'h00, exp_fs: 1'b0, exp_sp: 1'b0};
        end
        vecs[8]  = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 8'h01, 8'h01, 1'b1, 1'b0};

        rst = 1'b1; enable = 1'b1; wr_valid = 1'b1; swap_req = 1'b1;
        wr_row = 3'd2; wr_data = 8'h5A;
        enable2 = 1'b0; wr_valid2 = 1'b0; swap_req2 = 1'b0; wr_row2 = 3'd0; wr_data2 = 8'h00;

        // Reset with every input active
        for (int i = 0; i < 2; i++) begin
            tick();
            chk_quiet("rst");
            chk("rst_wr_ready", {7'd0, wr_ready}, 8'h01);
            chk("rst_sp", {7'd0, swap_pending}, 8'h00);
        end
        rst = 1'b0; wr_valid = 1'b0; swap_req = 1'b0;
        for (int i = 0; i < 8; i++) shown[i] = 8'h00;
        t = 0;
        scan(40);
        enable = 1'b0;
        tick();
        chk_quiet("disable");

        // Fill back buffer, request swap while idle, then enable
        for (int i = 0; i < 11; i++) begin
            enable = vecs[i].en; wr_valid = vecs[i].wv; wr_row = vecs[i].wrow;
            wr_data = vecs[i].wdat; swap_req = vecs[i].sreq;
            tick();
            chk("vec_row", row_sel, vecs[i].exp_row);
            chk("vec_col", col_data, vecs[i].exp_col);
            chk("vec_fs", {7'd0, frame_start}, {7'd0, vecs[i].exp_fs});
            chk("vec_sp", {7'd0, swap_pending}, {7'd0, vecs[i].exp_sp});
        end
        wr_valid = 1'b0;
        for (int i = 0; i < 8; i++) shown[i] = 8'h01 << i;
        t = 1;
        scan(95);

        // Row 3 is dwelling: write row 0 and request swap together, then a dropped write
        wr_valid = 1'b1; wr_row = 3'd0; wr_data = 8'hFF; swap_req = 1'b1;
        exp_sp = 1'b1;
        scan(1);
        chk("mid_wr_ready", {7'd0, wr_ready}, 8'h00);
        wr_row = 3'd1; wr_data = 8'hAA; swap_req = 1'b0;
        scan(1);
        wr_valid = 1'b0;
        scan(22);
        shown[0] = 8'hFF;
        for (int i = 1; i < 8; i++) shown[i] = 8'h00;
        exp_sp = 1'b0;
        scan(10);
        chk("post_swap_wr_ready", {7'd0, wr_ready}, 8'h01);
        scan(16);

        // Row 5 is dwelling: drop enable
        enable = 1'b0;
        tick();
        chk_quiet("en_drop");
        tick();
        chk_quiet("en_idle");
        enable = 1'b1;
        t = 0;
        scan(11);

        // Row 2 dwelling with a pending swap: reset
        swap_req = 1'b1;
        exp_sp = 1'b1;
        scan(1);
        swap_req = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk_quiet("midrst");
            chk("midrst_wr_ready", {7'd0, wr_ready}, 8'h01);
            chk("midrst_sp", {7'd0, swap_pending}, 8'h00);
        end
        rst = 1'b0;
        exp_sp = 1'b0;
        shown[0] = 8'h00;
        t = 0;
        scan(40);

        // Fast instance: one row per cycle, no blanking
        enable2 = 1'b1;
        for (int i = 0; i < 17; i++) begin
            logic [7:0] er;
            tick();
            er = 8'h01 << (i % 8);
            t  = i;
            chk("fast_row", row_sel2, er);
            chk("fast_col", col_data2, 8'h00);
            chk("fast_fs", {7'd0, frame_start2}, {7'd0, (i % 8) == 0});
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
